jtag_dtm_tap: RTL
=================

// Module: jtag_dtm_tap
// PURPOSE
//  JTAG TAP controller + RISC-V Debug Transport Module (0.13 DTM); the responder side of the debug JTAG port.
//  Oversamples TCK/TMS/TDI in the system clock domain and runs the 16-state TAP FSM.
//  Shifts IR/DR and turns DMI scans into request/response handshakes toward the debug module.
// PARAMETERS
//  IDCODE       32'h1E200A6D  value captured in IDCODE DR (bit0 must be 1)
//  ABITS        6             DMI address width; DMI DR width = ABITS+34
//  SYNC_STAGES  2             synchroniser flops on jtag_TCK/TMS/TDI (>=2)
// PORTS
//  clk            in   1      system clock, >= 8x TCK frequency
//  rst            in   1      synchronous reset, active-low
//  jtag_TCK       in   1      JTAG test clock (asynchronous, sampled)
//  jtag_TMS       in   1      test mode select
//  jtag_TDI       in   1      test data in
//  jtag_TDO       out  1      test data out
//  dmi_req_valid  out  1      DMI request valid, held until accepted
//  dmi_req_ready  in   1      debug module accepts request
//  dmi_req_addr   out  ABITS  DMI register address
//  dmi_req_data   out  32     DMI write data
//  dmi_req_op     out  2      1=read, 2=write
//  dmi_resp_valid in   1      DMI response valid
//  dmi_resp_ready out  1      high while a request is outstanding
//  dmi_resp_data  in   32     read data
//  dmi_resp_op    in   2      0=ok, 2=failed (3 treated as failed)
// BEHAVIOUR
//  - Sync: TCK/TMS/TDI through SYNC_STAGES flops; tck_rise/tck_fall = 1-clk pulses from last two TCK samples.
//  - TAP FSM (TLR,RTI,SEL_DR,CAP_DR,SH_DR,EX1_DR,PA_DR,EX2_DR,UPD_DR,SEL_IR,CAP_IR,SH_IR,EX1_IR,PA_IR,EX2_IR,UPD_IR)
//    advances only on tck_rise per IEEE 1149.1 using synced TMS; 5 rises with TMS=1 reach TLR from any state.
//  - On tck_rise, acting on the state BEFORE transition: CAP_x loads shift reg; SH_x shifts sr={TDI,sr[N-1:1]};
//    UPD_x commits. DR length selected by IR: IDCODE 32, DTMCS 32, DMI ABITS+34, BYPASS 1.
//  - IR 5 bits: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI, 0x1F or any other value BYPASS. In TLR: IR=0x01.
//    CAP_IR loads 5'b00001. BYPASS captures 0.
//  - TDO: on tck_fall, TDO<=sr[0] if state is SH_DR/SH_IR, else 0. Updates only on tck_fall.
//  - DTMCS capture: [31:18]=0,[17:16]=0,[15]=0,[14:12]=idle 3'd1,[11:10]=dmistat,[9:4]=ABITS,[3:0]=4'd1.
//    UPD_DR write: bit16 dmireset clears sticky dmistat; bit17 dmihardreset clears sticky, drops pending request,
//    deasserts dmi_req_valid and ignores the outstanding response.
//  - DMI DR = {addr[ABITS-1:0], data[31:0], op[1:0]}.
//    Capture loads {last_addr, last_rdata, st}, st=2'b11 if busy, else sticky dmistat.
//  - UPD_DR on DMI with op 1/2, not busy, sticky==0: latch addr/data/op; dmi_req_valid=1 on next clk; busy=1.
//    op 0 or 3: no request. Busy or sticky!=0: request dropped; busy case sets sticky=3.
//  - Handshake: req_valid drops the clk after valid&&ready. Response is accepted on resp_valid&&resp_ready.
//    Accept: last_rdata<=resp_data (reads only), busy=0. resp_op!=0 sets sticky=2 (sticky=3 takes priority).
//    resp_valid on the same clk as req accept is legal and completes the transaction.
//  - Address wrap: none; addr passed verbatim. Sticky is cleared only by rst, dmireset or dmihardreset.
//  - Reset (rst=0 at clk edge): TAP=TLR, IR=0x01, sr=0, TDO=0, req_valid=0, resp_ready=0, busy=0, sticky=0.
//    Also last_addr=0, last_rdata=0, req addr/data/op=0, sync flops=0.
//    Reset mid-scan or mid-request abandons everything; a late resp_valid is ignored.
//  - Latency: pin TCK rise -> FSM update SYNC_STAGES+1 clk; UPD_DR tck_rise -> dmi_req_valid 1 clk.
// TESTING
//  1 rst, then TMS=1 x8 then 0, shift IR 0x01, scan 32-bit DR -> TDO stream = IDCODE 0x1E200A6D, LSB first.
//  2 IR=0x11, scan {6'h10,32'h0,2'b10} -> dmi_req_valid, addr=0x10, data=0, op=2; ready=1 -> valid falls next clk.
//  3 IR=0x11, scan {6'h11,0,2'b01}; DM answers resp_data=0xDEADBEEF op 0; rescan op 0.
//    Expect returned {addr,data,op}={0x11,0xDEADBEEF,0}.
//  4 Rescan DMI while resp_valid held low -> captured op=3, sticky=3, no 2nd request.
//    Then DTMCS write bit16 -> capture dmistat=0.
//  5 IR=0x10 capture -> 0x00001061 (idle1,dmistat0,abits6,ver1). resp_op=2 -> next DTMCS dmistat=2.
//  6 rst low mid SH_DR with request pending -> TLR, req_valid=0, TDO=0. Late resp_valid ignored; IR reads 0x01.

Source files
------------

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP controller with a RISC-V 0.13 debug transport module behind it.
// TCK/TMS/TDI are oversampled in the clk domain, and DMI scans become request/response handshakes.
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE      = 32'h1E200A6D,
    parameter int          ABITS       = 6,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jtag_TCK,
    input  logic             jtag_TMS,
    input  logic             jtag_TDI,
    output logic             jtag_TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);
    localparam int DMI_W = ABITS + 34;
    localparam int SR_W  = DMI_W;
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t             state;
    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_prev;
    logic                   tck_rise, tck_fall, tms, tdi;
    logic [4:0]             ir;
    logic [SR_W-1:0]        sr;
    logic                   busy;
    logic [1:0]             sticky;
    logic [ABITS-1:0]       last_addr;
    logic [31:0]            last_rdata;
    logic [31:0]            dtmcs_cap;
    logic [DMI_W-1:0]       dmi_cap;

    assign tck_rise       = tck_sync[SYNC_STAGES-1] & ~tck_prev;
    assign tck_fall       = ~tck_sync[SYNC_STAGES-1] & tck_prev;
    assign tms            = tms_sync[SYNC_STAGES-1];
    assign tdi            = tdi_sync[SYNC_STAGES-1];
    assign dmi_resp_ready = busy;

    assign dtmcs_cap = {14'd0, 2'b00, 1'b0, 3'd1, sticky, 6'(ABITS), 4'd1};
    assign dmi_cap   = {last_addr, last_rdata, (busy ? 2'b11 : sticky)};

    function automatic tap_state_t next_state(input tap_state_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            UPD_IR:  return m ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    function automatic int dr_len(input logic [4:0] sel);
        case (sel)
            IR_IDCODE, IR_DTMCS: return 32;
            IR_DMI:              return DMI_W;
            default:             return 1;
        endcase
    endfunction

    // TDI enters at bit len-1 so the active register length varies with the IR.
    function automatic logic [SR_W-1:0] shift_sr(input logic [SR_W-1:0] v, input logic din,
                                                 input int len);
        logic [SR_W-1:0] shifted;
        logic [SR_W-1:0] r;
        shifted = {1'b0, v[SR_W-1:1]};
        r = '0;
        for (int i = 0; i < SR_W; i++) begin
            if (i == len - 1)
                r[i] = din;
            else if (i < len - 1)
                r[i] = shifted[i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= TLR;
            tck_sync      <= '0;
            tms_sync      <= '0;
            tdi_sync      <= '0;
            tck_prev      <= 1'b0;
            ir            <= IR_IDCODE;
            sr            <= '0;
            jtag_TDO      <= 1'b0;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            busy          <= 1'b0;
            sticky        <= 2'b00;
            last_addr     <= '0;
            last_rdata    <= '0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], jtag_TCK};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], jtag_TMS};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], jtag_TDI};
            tck_prev <= tck_sync[SYNC_STAGES-1];

            if (dmi_req_valid && dmi_req_ready)
                dmi_req_valid <= 1'b0;
            if (dmi_resp_valid && busy) begin
                busy          <= 1'b0;
                dmi_req_valid <= 1'b0;
                if (dmi_req_op == 2'd1)
                    last_rdata <= dmi_resp_data;
                if (dmi_resp_op != 2'd0 && sticky != 2'b11)
                    sticky <= 2'b10;
            end

            if (state == TLR)
                ir <= IR_IDCODE;

            if (tck_fall)
                jtag_TDO <= (state == SH_DR || state == SH_IR) ? sr[0] : 1'b0;

            // Actions are keyed on the state held before this TCK rise.
            if (tck_rise) begin
                state <= next_state(state, tms);
                case (state)
                    CAP_IR: sr <= {{(SR_W-5){1'b0}}, 5'b00001};
                    SH_IR:  sr <= shift_sr(sr, tdi, 5);
                    UPD_IR: ir <= sr[4:0];
                    CAP_DR: begin
                        case (ir)
                            IR_IDCODE: sr <= {{(SR_W-32){1'b0}}, IDCODE};
                            IR_DTMCS:  sr <= {{(SR_W-32){1'b0}}, dtmcs_cap};
                            IR_DMI:    sr <= dmi_cap;
                            default:   sr <= '0;
                        endcase
                    end
                    SH_DR:  sr <= shift_sr(sr, tdi, dr_len(ir));
                    UPD_DR: begin
                        if (ir == IR_DTMCS) begin
                            if (sr[17]) begin
                                sticky        <= 2'b00;
                                busy          <= 1'b0;
                                dmi_req_valid <= 1'b0;
                            end else if (sr[16]) begin
                                sticky <= 2'b00;
                            end
                        end else if (ir == IR_DMI && (sr[1:0] == 2'd1 || sr[1:0] == 2'd2)) begin
                            if (busy) begin
                                sticky <= 2'b11;
                            end else if (sticky == 2'b00) begin
                                dmi_req_valid <= 1'b1;
                                dmi_req_addr  <= sr[DMI_W-1:34];
                                dmi_req_data  <= sr[33:2];
                                dmi_req_op    <= sr[1:0];
                                last_addr     <= sr[DMI_W-1:34];
                                busy          <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
